// File: rtl/i2c_write_controller.sv
// Single-byte I2C write initiator: START, address+W, ACK, data byte, ACK, STOP.
// Optional I2C_NACK_RETRY_EN: one automatic restart after an address NACK.
//
//   state   | meaning
//   S_IDLE  | bus idle, waiting for start
//   S_START | START condition (SDA falls while SCL high)
//   S_ADDR  | 7 address bits + W bit, MSB first
//   S_ACK1  | address acknowledge slot
//   S_DATA  | 8 data bits, MSB first
//   S_ACK2  | data acknowledge slot
//   S_STOP  | STOP condition (SDA rises while SCL high)
module i2c_write_controller #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic [7:0] data_in,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       i2c_scl,
   inout  wire        i2c_sda
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_ACK1,
      S_DATA,
      S_ACK2,
      S_STOP
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       q;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic [7:0]       data_reg;
   logic             sda_oe;
   logic             nack;
`ifdef I2C_NACK_RETRY_EN
   logic [6:0]       addr_reg;
   logic             retried;
   logic             restart;
`endif

   assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

   // Outputs are registered: on each qtick the values for the quarter being entered are loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         q         <= 2'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
         data_reg  <= 8'd0;
         sda_oe    <= 1'b0;
         nack      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         i2c_scl   <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
         addr_reg  <= 7'd0;
         retried   <= 1'b0;
         restart   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if ((state == S_ACK1 || state == S_ACK2) && q == 2'd3 && div_cnt == '0)
            nack <= i2c_sda;

         if (state == S_IDLE) begin
            div_cnt <= '0;
            q       <= 2'd0;
            if (start) begin
               state     <= S_START;
               busy      <= 1'b1;
               ack_err   <= 1'b0;
               shift_reg <= {addr, 1'b0};
               data_reg  <= data_in;
`ifdef I2C_NACK_RETRY_EN
               addr_reg  <= addr;
               retried   <= 1'b0;
               restart   <= 1'b0;
`endif
            end
         end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            q       <= q + 2'd1;
            case (q)
               2'd0: begin
                  if (state == S_STOP)
                     i2c_scl <= 1'b1;
               end
               2'd1: begin
                  if (state == S_START)
                     sda_oe <= 1'b1;
                  else if (state == S_STOP)
                     sda_oe <= 1'b0;
                  else
                     i2c_scl <= 1'b1;
               end
               2'd2: ;
               default: begin
                  case (state)
                     S_START: begin
                        state   <= S_ADDR;
                        bit_cnt <= 3'd7;
                        i2c_scl <= 1'b0;
                        sda_oe  <= ~shift_reg[7];
                     end
                     S_ADDR, S_DATA: begin
                        i2c_scl <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                           bit_cnt   <= bit_cnt - 3'd1;
                           shift_reg <= {shift_reg[6:0], 1'b0};
                           sda_oe    <= ~shift_reg[6];
                        end else begin
                           state  <= (state == S_ADDR) ? S_ACK1 : S_ACK2;
                           sda_oe <= 1'b0;
                        end
                     end
                     S_ACK1: begin
                        i2c_scl <= 1'b0;
                        if (nack) begin
                           state  <= S_STOP;
                           sda_oe <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
                           if (!retried) begin
                              retried <= 1'b1;
                              restart <= 1'b1;
                           end else begin
                              ack_err <= 1'b1;
                           end
`else
                           ack_err <= 1'b1;
`endif
                        end else begin
                           state     <= S_DATA;
                           bit_cnt   <= 3'd7;
                           shift_reg <= data_reg;
                           sda_oe    <= ~data_reg[7];
                        end
                     end
                     S_ACK2: begin
                        i2c_scl <= 1'b0;
                        sda_oe  <= 1'b1;
                        ack_err <= nack;
                        state   <= S_STOP;
                     end
                     S_STOP: begin
`ifdef I2C_NACK_RETRY_EN
                        if (restart) begin
                           restart   <= 1'b0;
                           shift_reg <= {addr_reg, 1'b0};
                           state     <= S_START;
                        end else begin
                           state <= S_IDLE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            endcase
         end
      end
   end

endmodule
